// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths and state encoding for the nn output path
package nn_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int RES_WIDTH      = 19;
    localparam int DMA_ADDR_WIDTH = 6;
    localparam int CNT_WIDTH      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/nn_quant.sv
// rtl/nn_quant.sv - combinational shift / ReLU / saturate of a signed result to one byte
module nn_quant #(
    parameter int RES_WIDTH  = nn_pkg::RES_WIDTH,
    parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH
) (
    input  logic [RES_WIDTH-1:0]  i_result,
    input  logic [3:0]            i_shift,
    input  logic                  i_relu,
    output logic [DATA_WIDTH-1:0] o_byte
);
    import nn_pkg::*;

    localparam logic signed [RES_WIDTH-1:0] SAT_MAX = RES_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RES_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [RES_WIDTH-1:0] shifted;

    assign shifted = $signed(i_result) >>> i_shift;

    always_comb begin
        o_byte = shifted[DATA_WIDTH-1:0];
        if (i_relu && shifted[RES_WIDTH-1]) begin
            o_byte = '0;
        end else if (shifted > SAT_MAX) begin
            o_byte = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            o_byte = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/nn_out_wr.sv
// rtl/nn_out_wr.sv - output-side DMA writer: quantise PE results and pack two bytes per word
module nn_out_wr #(
    parameter int DATA_WIDTH     = nn_pkg::DATA_WIDTH,
    parameter int RES_WIDTH      = nn_pkg::RES_WIDTH,
    parameter int DMA_ADDR_WIDTH = nn_pkg::DMA_ADDR_WIDTH,
    parameter int CNT_WIDTH      = nn_pkg::CNT_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [DMA_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]      i_out_count,
    input  logic [3:0]                i_shift,
    input  logic                      i_relu,
    input  logic                      i_result_valid,
    input  logic [RES_WIDTH-1:0]      i_result,
    output logic                      o_result_ready,
    output logic                      o_dma_wr_en,
    output logic [DMA_ADDR_WIDTH-1:0] o_dma_wr_addr,
    output logic [2*DATA_WIDTH-1:0]   o_dma_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);
    import nn_pkg::*;

    wr_state_t                 state;
    wr_state_t                 state_nxt;

    logic [DMA_ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]      count_q;
    logic [3:0]                shift_q;
    logic                      relu_q;

    logic [CNT_WIDTH-1:0]      accepted;
    logic [DMA_ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-1:0]     pack_lo;
    logic [DATA_WIDTH-1:0]     q_byte;

    logic                      wr_en_q;
    logic [DMA_ADDR_WIDTH-1:0] wr_addr_q;
    logic [2*DATA_WIDTH-1:0]   wr_data_q;

    logic                      start_ok;
    logic                      accept;
    logic                      last_accept;
    logic                      wr_fire;
    logic                      flush_fire;

    nn_quant #(
        .RES_WIDTH  (RES_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_quant (
        .i_result (i_result),
        .i_shift  (shift_q),
        .i_relu   (relu_q),
        .o_byte   (q_byte)
    );

    assign start_ok    = (state == IDLE) && i_start;
    assign accept      = o_result_ready && i_result_valid;
    assign last_accept = accept && (accepted == count_q - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Even counts stay in RUN one extra cycle so the final pair write lands before DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = (i_out_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = count_q[0] ? FLUSH : RUN;
                end else if (accepted == count_q) begin
                    state_nxt = DONE;
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (state != IDLE);
        o_done         = (state == DONE);
        o_result_ready = (state == RUN) && (accepted < count_q);
        wr_fire        = 1'b0;
        flush_fire     = (state == FLUSH);
        if (accept && accepted[0]) begin
            wr_fire = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            base_q    <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            accepted  <= '0;
            word_idx  <= '0;
            pack_lo   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (start_ok) begin
                base_q   <= i_base_addr;
                count_q  <= i_out_count;
                shift_q  <= i_shift;
                relu_q   <= i_relu;
                accepted <= '0;
                word_idx <= '0;
                pack_lo  <= '0;
            end
            if (accept) begin
                accepted <= accepted + 1'b1;
                if (!accepted[0]) begin
                    pack_lo <= q_byte;
                end
            end
            wr_en_q <= wr_fire || flush_fire;
            // Address and data only move on a write so they hold between strobes.
            if (wr_fire) begin
                wr_addr_q <= base_q + word_idx;
                wr_data_q <= {q_byte, pack_lo};
                word_idx  <= word_idx + 1'b1;
            end else if (flush_fire) begin
                wr_addr_q <= base_q + word_idx;
                wr_data_q <= {{DATA_WIDTH{1'b0}}, pack_lo};
                word_idx  <= word_idx + 1'b1;
            end
        end
    end

    assign o_dma_wr_en   = wr_en_q;
    assign o_dma_wr_addr = wr_addr_q;
    assign o_dma_wr_data = wr_data_q;

endmodule

// File: tb/tb_nn_out_wr.sv
// tb/tb_nn_out_wr.sv - scoreboard bench for the nn output DMA writer
module tb_nn_out_wr;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [5:0]  i_base_addr;
    logic [9:0]  i_out_count;
    logic [3:0]  i_shift;
    logic        i_relu;
    logic        i_result_valid;
    logic [18:0] i_result;
    logic        o_result_ready;
    logic        o_dma_wr_en;
    logic [5:0]  o_dma_wr_addr;
    logic [15:0] o_dma_wr_data;
    logic        o_busy;
    logic        o_done;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  res_a[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    int acc_cnt = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;

    nn_out_wr dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_out_count    (i_out_count),
        .i_shift        (i_shift),
        .i_relu         (i_relu),
        .i_result_valid (i_result_valid),
        .i_result       (i_result),
        .o_result_ready (o_result_ready),
        .o_dma_wr_en    (o_dma_wr_en),
        .o_dma_wr_addr  (o_dma_wr_addr),
        .o_dma_wr_data  (o_dma_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int quant(input int r, input int sh, input bit relu);
        int s;
        s = r >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s & 255;
    endfunction

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (o_dma_wr_en) begin
            wr_t it;
            wr_cnt++;
            last_wr_cyc = cyc;
            chk("sb_has_entry", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk("wr_addr", 32'(o_dma_wr_addr), 32'(it.addr));
                chk("wr_data", 32'(o_dma_wr_data), 32'(it.data));
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (o_result_ready) ready_cnt++;
        if (o_result_ready && i_result_valid) acc_cnt++;
    end

    task automatic drive_one(input int v);
        bit got;
        got = 1'b0;
        i_result_valid = 1'b1;
        i_result = v[18:0];
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge i_clk);
            if (o_result_ready) got = 1'b1;
            @(posedge i_clk);
            #1;
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_job(input int base, input int cnt, input int sh, input bit relu,
                           input int gap_mask, input bit restart, input int extra);
        int  lo, w, b, a0, w0, d0;
        wr_t it;
        lo = 0;
        w  = 0;
        for (int i = 0; i < cnt; i++) begin
            b = quant(res_a[i], sh, relu);
            if (i % 2 == 0) begin
                lo = b;
            end else begin
                it.addr = 6'((base + w) % 64);
                it.data = 16'((b << 8) | lo);
                exp_q.push_back(it);
                w++;
            end
        end
        if (cnt % 2 == 1) begin
            it.addr = 6'((base + w) % 64);
            it.data = 16'(lo);
            exp_q.push_back(it);
        end
        a0 = acc_cnt;
        w0 = wr_cnt;
        d0 = done_cnt;

        @(posedge i_clk); #1;
        i_base_addr = 6'(base);
        i_out_count = 10'(cnt);
        i_shift     = 4'(sh);
        i_relu      = relu;
        i_start     = 1'b1;
        @(posedge i_clk); #1;
        i_start     = 1'b0;
        i_base_addr = 6'($urandom);
        i_out_count = 10'($urandom);
        i_shift     = 4'($urandom);
        i_relu      = 1'($urandom);
        chk("busy_after_start", 32'(o_busy), 1);
        if (restart) begin
            i_out_count = 10'd0;
            i_base_addr = 6'd40;
            i_start     = 1'b1;
            @(posedge i_clk); #1;
            i_start     = 1'b0;
        end

        for (int i = 0; i < cnt; i++) begin
            if (gap_mask[i]) begin
                i_result_valid = 1'b0;
                @(posedge i_clk); #1;
            end
            drive_one(res_a[i]);
        end
        if (extra == 0) i_result_valid = 1'b0;
        i_result = 19'h7ffff;
        @(negedge i_clk);
        chk("ready_after_last", 32'(o_result_ready), 0);
        @(posedge i_clk); #1;
        for (int k = 0; k < extra; k++) begin
            @(posedge i_clk); #1;
        end
        i_result_valid = 1'b0;

        for (int k = 0; k < 40 && done_cnt == d0; k++) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("accept_count", 32'(acc_cnt - a0), 32'(cnt));
        chk("write_count", 32'(wr_cnt - w0), 32'((cnt + 1) / 2));
        chk("sb_drained", 32'(exp_q.size()), 0);
        chk("idle_after_done", 32'(o_busy), 0);
        if (cnt % 2 == 0) chk("done_after_write", 32'(done_cyc), 32'(last_wr_cyc + 1));
    endtask

    initial begin
        int w0, r0, d0;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_out_count = '0;
        i_shift = '0;
        i_relu = 1'b0;
        i_result_valid = 1'b0;
        i_result = '0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_ready", 32'(o_result_ready), 0);
        chk("rst_wr_en", 32'(o_dma_wr_en), 0);
        chk("rst_wr_addr", 32'(o_dma_wr_addr), 0);
        chk("rst_wr_data", 32'(o_dma_wr_data), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        res_a = '{32'h0123, -80};
        run_job(5, 2, 4, 1'b0, 0, 1'b0, 0);

        res_a = '{5000, -5000};
        run_job(10, 2, 0, 1'b0, 0, 1'b0, 0);

        res_a = '{-5000, 3};
        run_job(11, 2, 0, 1'b1, 0, 1'b0, 0);

        res_a = '{1, 2, 3};
        run_job(0, 3, 0, 1'b0, 0, 1'b1, 3);

        res_a = '{10, 20, 30, 40};
        run_job(63, 4, 0, 1'b0, 32'b1010, 1'b0, 3);

        w0 = wr_cnt;
        r0 = ready_cnt;
        d0 = done_cnt;
        @(posedge i_clk); #1;
        i_out_count = 10'd0;
        i_base_addr = 6'd17;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("zero_done_next", 32'(o_done), 1);
        @(negedge i_clk);
        chk("zero_done_once", 32'(o_done), 0);
        chk("zero_no_write", 32'(wr_cnt - w0), 0);
        chk("zero_no_ready", 32'(ready_cnt - r0), 0);
        chk("zero_done_count", 32'(done_cnt - d0), 1);

        w0 = wr_cnt;
        @(posedge i_clk); #1;
        i_base_addr = 6'd9;
        i_out_count = 10'd4;
        i_shift = 4'd0;
        i_relu = 1'b0;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        drive_one(7);
        i_result_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_ready", 32'(o_result_ready), 0);
        chk("arst_wr_en", 32'(o_dma_wr_en), 0);
        chk("arst_wr_addr", 32'(o_dma_wr_addr), 0);
        chk("arst_wr_data", 32'(o_dma_wr_data), 0);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("arst_no_write", 32'(wr_cnt - w0), 0);

        res_a = '{16, 32};
        run_job(2, 2, 0, 1'b0, 0, 1'b0, 0);

        for (int j = 0; j < 4; j++) begin
            int cnt;
            cnt = int'($urandom_range(1, 9));
            res_a.delete();
            for (int i = 0; i < cnt; i++) begin
                res_a.push_back(int'($urandom_range(0, 400000)) - 200000);
            end
            run_job(int'($urandom_range(0, 63)), cnt, int'($urandom_range(0, 15)),
                    1'($urandom), int'($urandom_range(0, 511)), 1'b0, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
